corr_peak_find: RTL and testbench

CORR_PEAK_FIND -- requirements
Module: corr_peak_find

---
 rtl/corr_peak_find_if.sv | 12 +
 rtl/corr_peak_find.sv | 125 ++++++++++++
 tb/tb_corr_peak_find.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/corr_peak_find_if.sv
// rtl/corr_peak_find_if.sv - result-memory read port between the peak finder and the correlation RAM
interface corr_peak_find_if #(
    parameter int AW = 12,
    parameter int DW = 16
) ();
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic signed [DW-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/corr_peak_find.sv
// rtl/corr_peak_find.sv - scans LEN correlation words and reports the strongest one with its centred lag
module corr_peak_find #(
    parameter int LEN = 3999,
    parameter int DW  = 16,
    parameter int AW  = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abs_mode,
    corr_peak_find_if.master     mem,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        peak_idx,
    output logic signed [DW-1:0] peak_val,
    output logic signed [AW:0]   lag
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [AW-1:0]        LAST_ADDR = AW'(LEN - 1);
    localparam logic signed [AW:0]   CENTER    = (AW+1)'((LEN - 1) / 2);
    localparam logic signed [DW-1:0] MAX_POS   = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MIN_NEG   = {1'b1, {(DW-1){1'b0}}};

    state_t               state, state_nxt;
    logic [AW-1:0]        addr;
    logic                 vld;
    logic                 abs_q;
    logic                 have_best;
    logic [AW-1:0]        eval_idx;
    logic [AW-1:0]        best_idx;
    logic signed [DW-1:0] best_val;
    logic signed [DW-1:0] best_key;
    logic signed [DW-1:0] word_key;
    logic                 take;
    logic                 start_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (addr == LAST_ADDR) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The last word is in flight while vld is still high
                if (!vld) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state == READ) || (state == DRAIN);
    assign done        = (state == DONE);
    assign mem.rd_en   = (state == READ);
    assign mem.rd_addr = addr;

    // Magnitude of the most-negative word cannot be represented, so it saturates
    always_comb begin
        word_key = mem.rd_data;
        if (abs_q && mem.rd_data[DW-1]) begin
            word_key = (mem.rd_data == MIN_NEG) ? MAX_POS : -mem.rd_data;
        end
    end

    assign take = vld && (!have_best || (word_key > best_key));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            vld       <= 1'b0;
            abs_q     <= 1'b0;
            have_best <= 1'b0;
            eval_idx  <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            best_key  <= '0;
            peak_idx  <= '0;
            peak_val  <= '0;
            lag       <= '0;
        end else begin
            vld <= (state == READ);
            if (start_ok) begin
                addr      <= '0;
                abs_q     <= abs_mode;
                have_best <= 1'b0;
                eval_idx  <= '0;
            end else if (state == READ) begin
                addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            end
            if (vld) begin
                eval_idx <= eval_idx + 1'b1;
                if (take) begin
                    have_best <= 1'b1;
                    best_idx  <= eval_idx;
                    best_val  <= mem.rd_data;
                    best_key  <= word_key;
                end
            end
            if ((state == DRAIN) && !vld) begin
                peak_idx <= best_idx;
                peak_val <= best_val;
                lag      <= $signed({1'b0, best_idx}) - CENTER;
            end
        end
    end
endmodule

// File: tb/tb_corr_peak_find.sv
// tb/tb_corr_peak_find.sv - randomized and directed scans of corr_peak_find against a reference model
module tb_corr_peak_find;
    localparam int LEN = 7;
    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int MAXMAG = 2**(DW-1) - 1;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abs_mode = 1'b0;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        peak_idx;
    logic signed [DW-1:0] peak_val;
    logic signed [AW:0]   lag;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] mem [0:7] = '{default: '0};

    corr_peak_find_if #(.AW(AW), .DW(DW)) bus ();

    corr_peak_find #(.LEN(LEN), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abs_mode(abs_mode),
        .mem(bus), .busy(busy), .done(done),
        .peak_idx(peak_idx), .peak_val(peak_val), .lag(lag)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rd_data <= '0;
        end else if (bus.rd_en) begin
            bus.rd_data <= mem[bus.rd_addr];
        end
    end

    function automatic void chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    function automatic int ref_idx(input bit am);
        int best_i = 0;
        int best_k = 0;
        for (int i = 0; i < LEN; i++) begin
            int v = int'(mem[i]);
            int k = v;
            if (am) begin
                k = (v < 0) ? -v : v;
                if (k > MAXMAG) k = MAXMAG;
            end
            if (i == 0 || k > best_k) begin
                best_k = k;
                best_i = i;
            end
        end
        return best_i;
    endfunction

    // m_t counts edges since the accepted start; -1 means not scanning
    int m_t    = -1;
    bit m_done = 1'b0;
    int m_pidx = 0;
    int m_idx  = 0;
    int m_val  = 0;
    int m_lag  = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_t    <= -1;
            m_done <= 1'b0;
            m_idx  <= 0;
            m_val  <= 0;
            m_lag  <= 0;
        end else if (m_t < 0) begin
            if (start) begin
                m_t    <= 0;
                m_done <= 1'b0;
                m_pidx <= ref_idx(abs_mode);
            end
        end else if (m_t == LEN + 1) begin
            m_t    <= -1;
            m_done <= 1'b1;
            m_idx  <= m_pidx;
            m_val  <= int'(mem[m_pidx]);
            m_lag  <= m_pidx - (LEN - 1) / 2;
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, (m_t >= 0));
        chk("done", done, m_done);
        chk("rd_en", bus.rd_en, (m_t >= 0 && m_t < LEN));
        if (!reset_n || (m_t >= 0 && m_t < LEN)) begin
            chk("rd_addr", bus.rd_addr, reset_n ? m_t : 0);
        end
        chk("peak_idx", peak_idx, m_idx);
        chk("peak_val", peak_val, m_val);
        chk("lag", lag, m_lag);
    end

    task automatic load(input int v [LEN]);
        for (int i = 0; i < LEN; i++) mem[i] = DW'(v[i]);
    endtask

    task automatic run_scan(input bit am, input int pulse_edge, input bit noise);
        abs_mode = am;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_fall", done, 0);
        for (int e = 1; e <= LEN + 2; e++) begin
            start = (e == pulse_edge) || (noise && ($urandom % 3 == 0));
            if (noise) abs_mode = 1'($urandom % 2);
            @(posedge clk);
            #1;
            if (e < LEN + 2) chk("done_early", done, 0);
        end
        start = 1'b0;
        chk("done_latency", done, 1);
    endtask

    task automatic lit(input string nm, input int idx, input int val, input int lg);
        chk({nm, "_dut_idx"}, peak_idx, idx);
        chk({nm, "_dut_val"}, peak_val, val);
        chk({nm, "_dut_lag"}, lag, lg);
        chk({nm, "_mdl_idx"}, m_idx, idx);
        chk({nm, "_mdl_val"}, m_val, val);
        chk({nm, "_mdl_lag"}, m_lag, lg);
    endtask

    task automatic mid_reset(input bit am);
        abs_mode = am;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        start = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_peak_idx", peak_idx, 0);
        chk("rst_peak_val", peak_val, 0);
        chk("rst_lag", lag, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_done", done, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_peak_idx", peak_idx, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        load('{1, 3, 9, 2, 9, -4, 0});
        run_scan(1'b0, 0, 1'b0);
        lit("v1", 2, 9, -1);

        load('{0, 5, -20, 7, 0, 0, 19});
        run_scan(1'b1, 0, 1'b0);
        lit("v2_abs", 2, -20, -1);
        run_scan(1'b0, 0, 1'b0);
        lit("v2_sgn", 6, 19, 3);

        load('{-128, 127, 0, 0, 0, 0, 0});
        run_scan(1'b1, 0, 1'b0);
        lit("v3_sat", 0, -128, -3);

        load('{-5, -5, -5, -5, -5, -5, -5});
        run_scan(1'b0, 0, 1'b0);
        lit("v4_tie", 0, -5, -3);

        load('{1, 3, 9, 2, 9, -4, 0});
        run_scan(1'b0, 3, 1'b0);
        lit("v5_busy_start", 2, 9, -1);
        run_scan(1'b0, 0, 1'b0);
        lit("v5_restart", 2, 9, -1);

        mid_reset(1'b0);
        run_scan(1'b0, 0, 1'b0);
        lit("v6_after_rst", 2, 9, -1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < LEN; i++) begin
                case ($urandom % 6)
                    0: mem[i] = -8'sd128;
                    1: mem[i] = 8'sd127;
                    2: mem[i] = -8'sd127;
                    3: mem[i] = 8'sd0;
                    default: mem[i] = DW'($urandom_range(0, 255));
                endcase
            end
            if ($urandom % 8 == 0) mid_reset(1'($urandom % 2));
            run_scan(1'($urandom % 2), 0, 1'b1);
            if ($urandom % 2 == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
